// File: rtl/uart_tx_pkg.sv
// Shared UART TX encodings: line-mux selects, parity types, default frame width.
// Used by both the TX frame controller and the TX datapath.
package uart_tx_pkg;

    typedef enum logic [1:0] {
        MUX_START  = 2'd0,
        MUX_DATA   = 2'd1,
        MUX_PARITY = 2'd2,
        MUX_STOP   = 2'd3
    } mux_sel_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int UART_DATA_WIDTH = 8;

endpackage

// File: rtl/uart_parity_calc.sv
// Frame parity register: captures ^data ^ odd-select while the controller is idle/start, then holds
// through the data and parity slots so late PAR_TYP or data changes cannot corrupt the current frame.
module uart_parity_calc
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_ser_en,
    input  logic [1:0]            i_mux_sel,
    input  logic                  i_par_typ,
    output logic                  o_par
);

    logic w_upd;
    logic r_par;

    assign w_upd = !i_ser_en && (i_mux_sel != MUX_PARITY);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par <= 1'b0;
        end else if (w_upd) begin
            r_par <= (^i_data) ^ (i_par_typ == PAR_ODD);
        end
    end

    assign o_par = r_par;

endmodule

// File: rtl/uart_tx_datapath.sv
// UART TX datapath: LSB-first serializer, optional parity (UART_TX_PARITY_EN), registered line driver.
// TX_OUT lags mux_sel/data by one cycle; ser_done is combinational so the controller leaves data state in time.
module uart_tx_datapath
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] Data2Ser,
    input  logic                  ser_en,
    input  logic [1:0]            mux_sel,
    input  logic                  P_EN,
    input  logic                  PAR_TYP,
    output logic                  ser_done,
    output logic                  TX_OUT
);

    localparam int            CW       = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] r_shreg;
    logic [CW-1:0]         r_cnt;
    logic                  r_tx_out;
    logic                  w_line;
    logic                  w_par;
    logic                  w_unused;

    // P_EN is redundant here: the controller never selects the parity slot when it is low.
    assign w_unused = ^{P_EN, PAR_TYP};

    assign ser_done = ser_en && (r_cnt == LAST_BIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shreg <= '0;
        end else if (!ser_en) begin
            r_shreg <= Data2Ser;
        end else begin
            r_shreg <= {1'b0, r_shreg[DATA_WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (!ser_en || ser_done) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

`ifdef UART_TX_PARITY_EN
    uart_parity_calc #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity_calc (
        .clk       (clk),
        .rst       (rst),
        .i_data    (Data2Ser),
        .i_ser_en  (ser_en),
        .i_mux_sel (mux_sel),
        .i_par_typ (PAR_TYP),
        .o_par     (w_par)
    );
`else
    // Without parity a stray parity slot reads as an extra stop bit.
    assign w_par = 1'b1;
`endif

    always_comb begin
        w_line = 1'b1;
        case (mux_sel)
            MUX_START:  w_line = 1'b0;
            MUX_DATA:   w_line = r_shreg[0];
            MUX_PARITY: w_line = w_par;
            MUX_STOP:   w_line = 1'b1;
            default:    w_line = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_out <= 1'b1;
        end else begin
            r_tx_out <= w_line;
        end
    end

    assign TX_OUT = r_tx_out;

endmodule

// File: tb/tb_uart_tx_datapath.sv
// Directed bench for uart_tx_datapath: whole-frame line/ser_done patterns against hand-computed vectors.
module tb_uart_tx_datapath;
    import uart_tx_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] Data2Ser;
    logic       ser_en;
    logic [1:0] mux_sel;
    logic       P_EN;
    logic       PAR_TYP;
    logic       ser_done;
    logic       TX_OUT;

    int checks;
    int failures;

    uart_tx_datapath #(.DATA_WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .Data2Ser (Data2Ser),
        .ser_en   (ser_en),
        .mux_sel  (mux_sel),
        .P_EN     (P_EN),
        .PAR_TYP  (PAR_TYP),
        .ser_done (ser_done),
        .TX_OUT   (TX_OUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One controller cycle: drive, sample ser_done mid-cycle, sample the registered line after the edge.
    task automatic step(input logic [1:0] sel, input logic en, output logic done, output logic line);
        mux_sel = sel;
        ser_en  = en;
        @(negedge clk);
        done = ser_done;
        @(posedge clk);
        #1;
        line = TX_OUT;
    endtask

    // Line and ser_done bits are collected in time order, first bit in the MSB position.
    task automatic run_frame(input string tag, input logic [7:0] data, input logic ptyp,
                             input logic par_on, input logic toggle, input int n_data,
                             input logic [15:0] exp_line, input logic [15:0] exp_done);
        logic [15:0] got_line;
        logic [15:0] got_done;
        logic        d;
        logic        l;
        got_line = '0;
        got_done = '0;
        Data2Ser = data;
        PAR_TYP  = ptyp;
        P_EN     = par_on;
        step(MUX_START, 1'b0, d, l);
        got_line = {got_line[14:0], l};
        got_done = {got_done[14:0], d};
        for (int i = 0; i < n_data; i++) begin
            if (toggle) PAR_TYP = ~PAR_TYP;
            step(MUX_DATA, 1'b1, d, l);
            got_line = {got_line[14:0], l};
            got_done = {got_done[14:0], d};
        end
        if (par_on) begin
            if (toggle) PAR_TYP = ~ptyp;
            step(MUX_PARITY, 1'b0, d, l);
            got_line = {got_line[14:0], l};
            got_done = {got_done[14:0], d};
        end
        step(MUX_STOP, 1'b0, d, l);
        got_line = {got_line[14:0], l};
        got_done = {got_done[14:0], d};
        PAR_TYP = ptyp;
        chk({tag, "_line"}, {16'h0, got_line}, {16'h0, exp_line});
        chk({tag, "_done"}, {16'h0, got_done}, {16'h0, exp_done});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic d;
        logic l;
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        Data2Ser = 8'h00;
        ser_en   = 1'b0;
        mux_sel  = MUX_STOP;
        P_EN     = 1'b0;
        PAR_TYP  = PAR_EVEN;
        #12;
        chk("reset_tx_out", {31'h0, TX_OUT}, 32'h1);
        chk("reset_ser_done", {31'h0, ser_done}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

`ifdef UART_TX_PARITY_EN
        run_frame("a5_even", 8'hA5, PAR_EVEN, 1'b1, 1'b0, 8, 16'b01010010101, 16'b00000000100);
        run_frame("01_odd",  8'h01, PAR_ODD,  1'b1, 1'b0, 8, 16'b01000000001, 16'b00000000100);
        run_frame("07_odd_toggle", 8'h07, PAR_ODD, 1'b1, 1'b1, 8, 16'b01110000001, 16'b00000000100);
`else
        run_frame("a5_nopar", 8'hA5, PAR_EVEN, 1'b1, 1'b0, 8, 16'b01010010111, 16'b00000000100);
        run_frame("01_odd_nopar", 8'h01, PAR_ODD, 1'b1, 1'b0, 8, 16'b01000000011, 16'b00000000100);
        run_frame("07_odd_toggle_nopar", 8'h07, PAR_ODD, 1'b1, 1'b1, 8, 16'b01110000011, 16'b00000000100);
`endif
        run_frame("01_even", 8'h01, PAR_EVEN, 1'b1, 1'b0, 8, 16'b01000000011, 16'b00000000100);
        run_frame("07_even_toggle", 8'h07, PAR_EVEN, 1'b1, 1'b1, 8, 16'b01110000011, 16'b00000000100);
        run_frame("ff_noparity", 8'hFF, PAR_EVEN, 1'b0, 1'b0, 8, 16'b0111111111, 16'b0000000010);
        run_frame("abort", 8'hA5, PAR_EVEN, 1'b0, 1'b0, 3, 16'b01011, 16'b00000);
        run_frame("3c_after_abort", 8'h3C, PAR_EVEN, 1'b0, 1'b0, 8, 16'b0001111001, 16'b0000000010);

        // Asynchronous reset while the last data bit is on the serializer.
        Data2Ser = 8'h00;
        step(MUX_START, 1'b0, d, l);
        for (int i = 0; i < 7; i++) step(MUX_DATA, 1'b1, d, l);
        mux_sel = MUX_DATA;
        ser_en  = 1'b1;
        #2;
        chk("pre_reset_done", {31'h0, ser_done}, 32'h1);
        chk("pre_reset_line", {31'h0, TX_OUT}, 32'h0);
        rst = 1'b0;
        #1;
        chk("midframe_reset_tx_out", {31'h0, TX_OUT}, 32'h1);
        chk("midframe_reset_done", {31'h0, ser_done}, 32'h0);
        ser_en  = 1'b0;
        mux_sel = MUX_STOP;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            step(MUX_STOP, 1'b0, d, l);
            chk("idle_after_reset", {31'h0, l}, 32'h1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_datapath.md
# uart_tx_datapath

UART transmit datapath sitting directly downstream of the TX frame controller FSM. It consumes the controller's latched frame data, serializer enable and output-mux select, and produces the serial line plus the `ser_done` handshake the controller uses to leave its data state. It contains the LSB-first serializer, the parity generator and the registered line driver for the TX clock domain.

## Interface
- `DATA_WIDTH`, default 8: frame data bits; legal values 5..9.
- `clk`  input  1  TX-domain clock; one line bit per cycle.
- `rst`  input  1  asynchronous, active-low reset.
- `Data2Ser`  input  DATA_WIDTH  frame data from the controller, stable from start bit to stop bit.
- `ser_en`  input  1  high while the controller is in its data state.
- `mux_sel`  input  2  line source: 0 start, 1 data, 2 parity, 3 stop/idle.
- `P_EN`  input  1  parity enabled for this frame; informational only, since the controller already skips mux_sel=2 when it is low.
- `PAR_TYP`  input  1  0 even, 1 odd.
- `ser_done`  output  1  last data bit is being presented this cycle.
- `TX_OUT`  output  1  serial line, registered.

## Operation
- Shift register `shreg`:
  - While ser_en=0, it loads Data2Ser every cycle.
  - While ser_en=1, it shifts right by one each cycle with zero fill.
  - The serial data bit is always `shreg[0]`.
- Bit counter `cnt` is $clog2(DATA_WIDTH) bits wide.
  - It clears while ser_en=0.
  - It increments while ser_en=1 and cnt<DATA_WIDTH-1.
  - It wraps to 0 on the cycle ser_done=1.
- `ser_done` = ser_en && (cnt==DATA_WIDTH-1). It is combinational from registers, so the controller sees it in the same cycle.
- Parity register `par`:
  - It updates to ^Data2Ser ^ PAR_TYP on every cycle with ser_en=0 and mux_sel≠2.
  - It holds otherwise, which makes it stable through the data and parity bits.
  - A PAR_TYP change while ser_en=1 or mux_sel=2 has no effect on the current frame.
- Line mux, registered into TX_OUT on every cycle:
  - mux_sel=0 → 0
  - mux_sel=1 → shreg[0]
  - mux_sel=2 → par
  - mux_sel=3 → 1
- ser_en dropping before ser_done means the frame is aborted. cnt clears and shreg reloads on the next edge, and no ser_done is issued.
- ser_en=1 with mux_sel≠1 is an illegal combination. The counter still advances, and TX_OUT follows mux_sel.

## Timing
- Reset values: TX_OUT=1, ser_done=0, shreg=0, cnt=0, par=0.
- An asynchronous reset mid-frame returns to these values at once. The line idles high on the first edge after release.
- Latency is one cycle from mux_sel/data to TX_OUT. Every line bit is therefore delayed uniformly by one clock relative to the controller state.
- Data phase lasts exactly DATA_WIDTH cycles of ser_en=1, and ser_done is high on the last of them.
- Full frame on TX_OUT:
  - 1 start bit, DATA_WIDTH data bits, [1 parity bit], 1 stop bit.
  - Total DATA_WIDTH+3 cycles with parity, DATA_WIDTH+2 without.
- Back-to-back frames: ser_en=0 for at least one cycle between frames (the start bit) guarantees reload of shreg and par.

## Configuration
- `UART_TX_PARITY_EN` defined: the parity register and calculator are present. mux_sel=2 drives par.
- `UART_TX_PARITY_EN` undefined: no parity logic is present, and PAR_TYP and P_EN are ignored. mux_sel=2 drives 1, so a stray parity slot looks like an extra stop bit.

## Structure
- Package `uart_tx_pkg` holds:
  - the mux_sel encodings MUX_START=2'd0, MUX_DATA=2'd1, MUX_PARITY=2'd2, MUX_STOP=2'd3;
  - PAR_EVEN=1'b0, PAR_ODD=1'b1;
  - the default DATA_WIDTH.
  - The controller FSM uses the same package.
- One sub-module, `uart_parity_calc`, containing the par register, its update enable and the PAR_TYP handling. It is instantiated only under UART_TX_PARITY_EN.

## Test plan
- Reset: assert rst low mid-shift → TX_OUT=1, ser_done=0 immediately. After release, idle with mux_sel=3 → TX_OUT stays 1.
- Data2Ser=8'hA5, even, parity on → TX_OUT sequence 0, 1,0,1,0,0,1,0,1, 0, 1. ser_done is high only on the 8th ser_en cycle.
- Data2Ser=8'h01: odd → parity bit 0; even → parity bit 1.
- Parity off (controller skips mux_sel=2), Data2Ser=8'hFF → 0, eight 1s, 1. Frame length 10 cycles.
- Abort: drop ser_en after 3 data cycles → no ser_done. The next frame with 8'h3C serializes 0,0,1,1,1,1,0,0 correctly.
- PAR_TYP toggled during the data phase with Data2Ser=8'h07, PAR_TYP=0 at load → parity bit 1. Build without UART_TX_PARITY_EN → mux_sel=2 drives 1.
